// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and defaults for the instruction fetch front end.
package mips_fetch_pkg;
    typedef enum logic [0:0] {S_BOOT, S_FETCH} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
endpackage

// File: rtl/if_inst_fifo.sv
// if_inst_fifo: synchronous FIFO with flush, used for the decode buffer and the in-flight PC queue.
module if_inst_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_comb begin
        rd_d  = flush ? '0 : do_pop ? nxt(rd_q) : rd_q;
        wr_d  = flush ? '0 : do_push ? nxt(wr_q) : wr_q;
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: in-order instruction fetch with decode buffer and branch redirect/squash.
// Define IF_REDIRECT_STATS_EN to add the Redirect_Cnt/Squash_Cnt statistics outputs.
module if_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch,
    input  logic [31:0] Branch_To,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Gnt,
    input  logic        IM_Rvalid,
    input  logic [31:0] IM_Rdata,
    input  logic        ID_Ready,
`ifdef IF_REDIRECT_STATS_EN
    output logic [31:0] Redirect_Cnt,
    output logic [31:0] Squash_Cnt,
`endif
    output logic        Inst_Valid,
    output logic [31:0] Inst,
    output logic [31:0] Inst_PC
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] out_q, out_d, sq_q, sq_d, pc_cnt;
    logic [CW-1:0] buf_cnt;
    logic          rv, grant, drop, buf_push, buf_pop, buf_full, buf_empty, pc_full, pc_empty;
    logic [31:0]   pc_head;
    fetch_entry_t  buf_head, buf_din;
    // Responses after a reset belong to a memory that was reset too, so nothing outstanding means ignore.
    assign rv         = IM_Rvalid && out_q != '0;
    assign IM_Req     = state_q == S_FETCH && !Branch && 32'(out_q) + 32'(buf_cnt) < 32'(DEPTH)
                        && 32'(out_q) < 32'(MAX_OUT);
    assign IM_Addr    = pc_q & ~32'h3;
    assign grant      = IM_Req && IM_Gnt;
    assign drop       = rv && (Branch || sq_q != '0);
    assign buf_push   = rv && !drop;
    assign buf_pop    = !buf_empty && ID_Ready && !Branch;
    assign buf_din    = '{pc: pc_head, inst: IM_Rdata};
    assign Inst_Valid = !buf_empty;
    assign Inst       = buf_head.inst;
    assign Inst_PC    = buf_head.pc;
    always_comb begin
        state_d = S_FETCH;
        pc_d    = Branch ? Branch_To : grant ? pc_q + 32'd4 : pc_q;
        out_d   = out_q + OW'(grant) - OW'(rv);
        sq_d    = Branch ? out_d : sq_q - OW'(rv && sq_q != '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            sq_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            sq_q    <= sq_d;
        end
    end
    if_inst_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
        .clk(clk), .rst(rst), .push(buf_push), .pop(buf_pop), .flush(Branch),
        .din(buf_din), .dout(buf_head), .full(buf_full), .empty(buf_empty), .count(buf_cnt)
    );
    if_inst_fifo #(.W(32), .DEPTH(MAX_OUT)) u_pcq (
        .clk(clk), .rst(rst), .push(grant), .pop(buf_push), .flush(Branch),
        .din(IM_Addr), .dout(pc_head), .full(pc_full), .empty(pc_empty), .count(pc_cnt)
    );
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(buf_push && buf_full));
    a_pcq_push:    assert property (@(posedge clk) disable iff (rst) !(grant && pc_full));
    a_pcq_pop:     assert property (@(posedge clk) disable iff (rst) !(buf_push && pc_empty));
    a_pcq_track:   assert property (@(posedge clk) disable iff (rst) 32'(pc_cnt) + 32'(sq_q) == 32'(out_q));
`ifdef IF_REDIRECT_STATS_EN
    logic [31:0] redir_q, redir_d, sqc_q, sqc_d;
    always_comb begin
        redir_d = redir_q + 32'(Branch);
        sqc_d   = sqc_q + 32'(drop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_q <= '0;
            sqc_q   <= '0;
        end else begin
            redir_q <= redir_d;
            sqc_q   <= sqc_d;
        end
    end
    assign Redirect_Cnt = redir_q;
    assign Squash_Cnt   = sqc_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch scenarios checked against an epoch-tagged memory/decode model.
// Build with IF_REDIRECT_STATS_EN defined to also check the redirect statistics.
module tb_if_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 4;
    logic clk = 0, rst = 1, Branch = 0, IM_Gnt = 0, IM_Rvalid = 0, ID_Ready = 0;
    logic [31:0] Branch_To = 0, IM_Rdata = 0;
    logic IM_Req, Inst_Valid;
    logic [31:0] IM_Addr, Inst, Inst_PC;
`ifdef IF_REDIRECT_STATS_EN
    logic [31:0] Redirect_Cnt, Squash_Cnt;
`endif
    if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .Branch(Branch), .Branch_To(Branch_To),
        .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Gnt(IM_Gnt),
        .IM_Rvalid(IM_Rvalid), .IM_Rdata(IM_Rdata), .ID_Ready(ID_Ready),
`ifdef IF_REDIRECT_STATS_EN
        .Redirect_Cnt(Redirect_Cnt), .Squash_Cnt(Squash_Cnt),
`endif
        .Inst_Valid(Inst_Valid), .Inst(Inst), .Inst_PC(Inst_PC)
    );
    always #5 clk = ~clk;

    // Each request carries the redirect epoch it was issued in; a response is right-path only if its epoch is current.
    typedef struct {logic [31:0] addr; int ep; int due;} req_t;
    req_t pend[$];
    logic [31:0] avail[$], gnt_log[$], pop_log[$];
    logic [31:0] m_pc = RST_PC, st_red = 0, st_sq = 0;
    int epoch = 0, cyc = 0, lat = 1, vectors = 0, miscompares = 0;
    bit in_fetch = 0;
    logic s_valid, s_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_req();
        return in_fetch && !Branch && pend.size() + avail.size() < DEPTH && pend.size() < MAX_OUT;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        bit req_e, pop;
        req_t r;
        @(negedge clk);
        req_e = exp_req();
        s_valid = Inst_Valid;
        s_req = IM_Req;
        if (!rst) begin
            chk("im_req", 32'(IM_Req), 32'(req_e));
            if (req_e) chk("im_addr", IM_Addr, m_pc);
            chk("inst_valid", 32'(Inst_Valid), 32'(avail.size() > 0));
            if (avail.size() > 0) begin
                chk("inst_pc", Inst_PC, avail[0]);
                chk("inst", Inst, mem_word(avail[0]));
            end
`ifdef IF_REDIRECT_STATS_EN
            chk("redirect_cnt", Redirect_Cnt, st_red);
            chk("squash_cnt", Squash_Cnt, st_sq);
`endif
            if (IM_Req && IM_Gnt) gnt_log.push_back(IM_Addr);
            if (Inst_Valid && ID_Ready && !Branch) pop_log.push_back(Inst_PC);
        end
        pop = avail.size() > 0 && ID_Ready && !Branch;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            avail.delete();
            m_pc = RST_PC;
            in_fetch = 0;
            epoch = 0;
            st_red = 0;
            st_sq = 0;
        end else begin
            if (pop) void'(avail.pop_front());
            if (IM_Rvalid && pend.size() > 0) begin
                r = pend.pop_front();
                if (!Branch && r.ep == epoch) avail.push_back(r.addr);
                else st_sq++;
            end
            if (req_e && IM_Gnt) begin
                pend.push_back('{m_pc, epoch, cyc + lat});
                m_pc += 32'd4;
            end
            if (Branch) begin
                avail.delete();
                epoch++;
                m_pc = Branch_To & ~32'h3;
                st_red++;
            end
            in_fetch = 1;
        end
        cyc++;
        #1;
        IM_Rvalid = pend.size() > 0 && pend[0].due <= cyc;
        IM_Rdata = IM_Rvalid ? mem_word(pend[0].addr) : 32'h0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        pop_log.delete();
    endtask

    task automatic do_reset();
        rst = 1;
        cycles(2);
        rst = 0;
        clear_logs();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        Branch = 1;
        Branch_To = tgt;
        cycle();
        Branch = 0;
    endtask

    // Three requests in flight, then a redirect to 0x00400020.
    task automatic scen3();
        IM_Gnt = 0;
        ID_Ready = 1;
        lat = 5;
        cycles(8);
        clear_logs();
        IM_Gnt = 1;
        cycles(3);
        chk("s3_inflight", 32'(gnt_log.size()), 32'd3);
        redirect(32'h0040_0020);
        cycles(20);
        chk("s3_redirect_addr", gnt_log[3], 32'h0040_0020);
        chk("s3_first_pc", pop_log[0], 32'h0040_0020);
        chk("s3_first_inst", mem_word(pop_log[0]), mem_word(32'h0040_0020));
    endtask

    initial begin
        // 1: streaming with 1-cycle latency.
        lat = 1;
        IM_Gnt = 1;
        ID_Ready = 1;
        do_reset();
        cycle();
        chk("reset_valid", 32'(s_valid), 32'd0);
        chk("boot_req", 32'(s_req), 32'd0);
        cycles(11);
        chk("s1_gnt0", gnt_log[0], 32'hBFC0_0000);
        chk("s1_gnt1", gnt_log[1], 32'hBFC0_0004);
        chk("s1_pop0", pop_log[0], 32'hBFC0_0000);
        chk("s1_pop1", pop_log[1], 32'hBFC0_0004);
        // 2: decode stall fills the buffer, then drains in order.
        ID_Ready = 0;
        do_reset();
        cycles(12);
        chk("s2_grants", 32'(gnt_log.size()), 32'd4);
        chk("s2_req_off", 32'(s_req), 32'd0);
        ID_Ready = 1;
        cycles(10);
        for (int i = 0; i < 4; i++) chk("s2_pop", pop_log[i], 32'hBFC0_0000 + 32'(4 * i));
        chk("s2_resume", gnt_log[4], 32'hBFC0_0010);
        // 3: redirect with three wrong-path responses still outstanding.
        do_reset();
        scen3();
        chk("s3_first_gnt", gnt_log[0], 32'hBFC0_0000);
        // 4: redirect lands in the same cycle as a response, with an unaligned target.
        lat = 3;
        IM_Gnt = 1;
        ID_Ready = 1;
        do_reset();
        cycles(3);
        IM_Gnt = 0;
        cycles(1);
        redirect(32'h0000_1002);
        IM_Gnt = 1;
        cycles(12);
        chk("s4_redirect_addr", gnt_log[2], 32'h0000_1000);
        chk("s4_first_pc", pop_log[0], 32'h0000_1000);
        // 4b: back-to-back redirects, the last one wins.
        lat = 2;
        clear_logs();
        redirect(32'h0000_2000);
        redirect(32'h0000_3003);
        cycles(12);
        chk("s4b_gnt", gnt_log[0], 32'h0000_3000);
        chk("s4b_pop", pop_log[0], 32'h0000_3000);
        // 5: reset in the middle of traffic.
        lat = 4;
        ID_Ready = 0;
        IM_Gnt = 1;
        do_reset();
        cycles(7);
        chk("s5_buffered", 32'(s_valid), 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        chk("s5_valid_after_rst", 32'(s_valid), 32'd0);
        chk("s5_req_after_rst", 32'(s_req), 32'd0);
        ID_Ready = 1;
        clear_logs();
        cycles(12);
        chk("s5_restart_gnt", gnt_log[0], 32'hBFC0_0000);
        chk("s5_restart_pop", pop_log[0], 32'hBFC0_0000);
`ifdef IF_REDIRECT_STATS_EN
        // 6: two redirects, three squashed words each.
        do_reset();
        scen3();
        scen3();
        cycle();
        chk("s6_redirect_cnt", Redirect_Cnt, 32'd2);
        chk("s6_squash_cnt", Squash_Cnt, 32'd6);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
